// File: rtl/weight_load_scheduler.sv
// weight_load_scheduler
// Walks the MAC array through a weight-load job one kernel group at a time.
// Each group is a short burst of BRAM reads, one or two rows each, followed
// by a single load strobe to the MAC array. kernel_size and num_groups are
// latched when a job starts. Every output except load_weight comes from
// registered state and counters. load_weight follows mac_ready while in LOAD,
// so the strobe lands on the cycle the array accepts it.
module weight_load_scheduler #(
    parameter int GROUP_WIDTH = 8,
    parameter int MAX_READS   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4:0]             kernel_size,
    input  logic [GROUP_WIDTH-1:0] num_groups,
    input  logic                   data_valid,
    input  logic                   mac_ready,
    output logic                   address_reset,
    output logic                   read_en,
    output logic                   read_len,
    output logic [$clog2(MAX_READS)-1:0] read_idx,
    output logic                   load_weight,
    output logic [GROUP_WIDTH-1:0] group_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    localparam int IDX_W = $clog2(MAX_READS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_ADDR,
        S_READ,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IDX_W-1:0]       r_read_idx;
    logic [IDX_W-1:0]       w_read_idx_next;
    logic [GROUP_WIDTH-1:0] r_group_idx;
    logic [GROUP_WIDTH-1:0] w_group_idx_next;
    logic [4:0]             r_kernel;
    logic [4:0]             w_kernel_next;
    logic [GROUP_WIDTH-1:0] r_num_groups;
    logic [GROUP_WIDTH-1:0] w_num_groups_next;
    logic                   r_cfg_err;
    logic                   w_cfg_err_next;

    logic                   w_cfg_ok;
    logic [IDX_W-1:0]       w_last_idx;
    logic                   w_len;

    // A job is legal only with exactly one kernel size bit and a non-zero group count.
    assign w_cfg_ok = ($countones(kernel_size) == 1) && (num_groups != '0);

    // Read schedule: index of the last read in a group, and the port length for the current read.
    always_comb begin
        w_last_idx = '0;
        w_len      = 1'b0;
        case (r_kernel)
            5'b00001: begin
                w_last_idx = '0;
                w_len      = 1'b0;
            end
            5'b00010: begin
                w_last_idx = '0;
                w_len      = 1'b1;
            end
            5'b00100: begin
                w_last_idx = IDX_W'(1);
                w_len      = (r_read_idx == '0);
            end
            5'b01000: begin
                w_last_idx = IDX_W'(1);
                w_len      = 1'b1;
            end
            5'b10000: begin
                w_last_idx = IDX_W'(2);
                w_len      = (r_read_idx != IDX_W'(2));
            end
            default: begin
                w_last_idx = '0;
                w_len      = 1'b0;
            end
        endcase
    end

    // Next-state and counter update logic.
    always_comb begin
        w_state_next      = r_state;
        w_read_idx_next   = r_read_idx;
        w_group_idx_next  = r_group_idx;
        w_kernel_next     = r_kernel;
        w_num_groups_next = r_num_groups;
        w_cfg_err_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_kernel_next     = kernel_size;
                        w_num_groups_next = num_groups;
                        w_read_idx_next   = '0;
                        w_group_idx_next  = '0;
                        w_state_next      = S_RST_ADDR;
                    end else begin
                        w_cfg_err_next = 1'b1;
                    end
                end
            end
            S_RST_ADDR: begin
                w_state_next = S_READ;
            end
            S_READ: begin
                if (data_valid) begin
                    if (r_read_idx == w_last_idx) begin
                        w_read_idx_next = '0;
                        w_state_next    = S_LOAD;
                    end else begin
                        w_read_idx_next = r_read_idx + IDX_W'(1);
                    end
                end
            end
            S_LOAD: begin
                if (mac_ready) begin
                    if (r_group_idx == r_num_groups - GROUP_WIDTH'(1)) begin
                        w_state_next = S_DONE;
                    end else begin
                        // BRAM address counters keep running between groups.
                        w_group_idx_next = r_group_idx + GROUP_WIDTH'(1);
                        w_state_next     = S_READ;
                    end
                end
            end
            S_DONE: begin
                w_group_idx_next = '0;
                w_state_next     = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_read_idx   <= '0;
            r_group_idx  <= '0;
            r_kernel     <= '0;
            r_num_groups <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_read_idx   <= w_read_idx_next;
            r_group_idx  <= w_group_idx_next;
            r_kernel     <= w_kernel_next;
            r_num_groups <= w_num_groups_next;
            r_cfg_err    <= w_cfg_err_next;
        end
    end

    assign address_reset = (r_state == S_RST_ADDR);
    assign read_en       = (r_state == S_READ);
    assign read_len      = (r_state == S_READ) && w_len;
    assign read_idx      = r_read_idx;
    assign load_weight   = (r_state == S_LOAD) && mac_ready;
    assign group_idx     = r_group_idx;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_weight_load_scheduler.sv
// Directed bench for weight_load_scheduler. Each job is driven cycle by cycle
// from per-cycle patterns. Outputs are captured into per-cycle masks and then
// compared against hand-derived cycle positions.
module tb_weight_load_scheduler;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] kernel_size;
    logic [7:0] num_groups;
    logic       data_valid;
    logic       mac_ready;
    logic       address_reset;
    logic       read_en;
    logic       read_len;
    logic [1:0] read_idx;
    logic       load_weight;
    logic [7:0] group_idx;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int n_tests;
    int n_fail;

    logic [63:0] dv_pat, mr_pat, st_pat, rst_pat;
    logic [4:0]  mid_ks;
    logic [7:0]  mid_ng;

    logic [63:0] m_ar, m_re, m_rl, m_lw, m_dn, m_bz, m_cfg;
    logic [1:0]  ri_v [0:63];
    logic [7:0]  gi_v [0:63];

    weight_load_scheduler #(.GROUP_WIDTH(8), .MAX_READS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .kernel_size  (kernel_size),
        .num_groups   (num_groups),
        .data_valid   (data_valid),
        .mac_ready    (mac_ready),
        .address_reset(address_reset),
        .read_en      (read_en),
        .read_len     (read_len),
        .read_idx     (read_idx),
        .load_weight  (load_weight),
        .group_idx    (group_idx),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the cycle in which start is driven; outputs are sampled 2 time units after each edge.
    task automatic run_job(input logic [4:0] ks, input logic [7:0] ng, input int ncyc);
        m_ar = '0; m_re = '0; m_rl = '0; m_lw = '0; m_dn = '0; m_bz = '0; m_cfg = '0;
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            start       = (c == 0) || st_pat[c];
            kernel_size = (c == 0) ? ks : mid_ks;
            num_groups  = (c == 0) ? ng : mid_ng;
            data_valid  = dv_pat[c];
            mac_ready   = mr_pat[c];
            rst         = rst_pat[c];
            #1;
            m_ar[c]  = address_reset;
            m_re[c]  = read_en;
            m_rl[c]  = read_len;
            m_lw[c]  = load_weight;
            m_dn[c]  = done;
            m_bz[c]  = busy;
            m_cfg[c] = cfg_err;
            ri_v[c]  = read_idx;
            gi_v[c]  = group_idx;
        end
        start = 1'b0;
        rst   = 1'b0;
        $display("[TB] job k=%b ng=%0d ar=%h re=%h rl=%h lw=%h done=%h busy=%h cfg=%h",
                 ks, ng, m_ar, m_re, m_rl, m_lw, m_dn, m_bz, m_cfg);
    endtask

    task automatic set_default_pats();
        dv_pat  = '1;
        mr_pat  = '1;
        st_pat  = '0;
        rst_pat = '0;
        mid_ks  = 5'b10000;
        mid_ng  = 8'd7;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; start = 1'b0; kernel_size = '0; num_groups = '0;
        data_valid = 1'b0; mac_ready = 1'b0;
        set_default_pats();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs",
                 {60'd0, address_reset, read_en, read_len, read_idx, load_weight,
                  group_idx, busy, done, cfg_err}, 64'd0);
        rst = 1'b0;

        // K1, one group
        set_default_pats();
        run_job(5'b00001, 8'd1, 8);
        check_eq("k1_ar",   m_ar,  64'h2);
        check_eq("k1_re",   m_re,  64'h4);
        check_eq("k1_rl",   m_rl,  64'h0);
        check_eq("k1_lw",   m_lw,  64'h8);
        check_eq("k1_done", m_dn,  64'h10);
        check_eq("k1_busy", m_bz,  64'h1E);
        check_eq("k1_cfg",  m_cfg, 64'h0);

        // K5, two groups
        set_default_pats();
        run_job(5'b10000, 8'd2, 14);
        check_eq("k5_ar",   m_ar, 64'h2);
        check_eq("k5_re",   m_re, 64'h1DC);
        check_eq("k5_rl",   m_rl, 64'hCC);
        check_eq("k5_lw",   m_lw, 64'h220);
        check_eq("k5_done", m_dn, 64'h400);
        check_eq("k5_busy", m_bz, 64'h7FE);
        check_eq("k5_ri2",  {62'd0, ri_v[2]}, 64'd0);
        check_eq("k5_ri3",  {62'd0, ri_v[3]}, 64'd1);
        check_eq("k5_ri4",  {62'd0, ri_v[4]}, 64'd2);
        check_eq("k5_gi5",  {56'd0, gi_v[5]}, 64'd0);
        check_eq("k5_gi8",  {56'd0, gi_v[8]}, 64'd1);
        check_eq("k5_gi9",  {56'd0, gi_v[9]}, 64'd1);
        check_eq("k5_gi11", {56'd0, gi_v[11]}, 64'd0);

        // K3, data_valid held low for the first four READ cycles
        set_default_pats();
        dv_pat[5:2] = 4'b0000;
        run_job(5'b00100, 8'd1, 12);
        check_eq("k3_re",   m_re, 64'hFC);
        check_eq("k3_rl",   m_rl, 64'h7C);
        check_eq("k3_ri5",  {62'd0, ri_v[5]}, 64'd0);
        check_eq("k3_ri7",  {62'd0, ri_v[7]}, 64'd1);
        check_eq("k3_lw",   m_lw, 64'h100);
        check_eq("k3_done", m_dn, 64'h200);
        check_eq("k3_busy", m_bz, 64'h3FE);

        // K2, three groups, mac_ready low for three cycles in LOAD of group 1
        set_default_pats();
        mr_pat[7:5] = 3'b000;
        run_job(5'b00010, 8'd3, 14);
        check_eq("k2_re",   m_re, 64'h214);
        check_eq("k2_rl",   m_rl, 64'h214);
        check_eq("k2_lw",   m_lw, 64'h508);
        check_eq("k2_gi8",  {56'd0, gi_v[8]}, 64'd1);
        check_eq("k2_gi10", {56'd0, gi_v[10]}, 64'd2);
        check_eq("k2_done", m_dn, 64'h800);
        check_eq("k2_busy", m_bz, 64'hFFE);

        // Illegal kernel_size
        set_default_pats();
        run_job(5'b00110, 8'd1, 4);
        check_eq("badk_cfg",  m_cfg, 64'h2);
        check_eq("badk_busy", m_bz,  64'h0);
        check_eq("badk_re",   m_re,  64'h0);
        check_eq("badk_ar",   m_ar,  64'h0);

        // num_groups of zero
        set_default_pats();
        run_job(5'b00001, 8'd0, 4);
        check_eq("ng0_cfg",  m_cfg, 64'h2);
        check_eq("ng0_busy", m_bz,  64'h0);
        check_eq("ng0_re",   m_re,  64'h0);

        // Start held high mid-job with an illegal config is ignored
        set_default_pats();
        st_pat[3:1] = 3'b111;
        mid_ks = 5'b00110;
        mid_ng = 8'd0;
        run_job(5'b00001, 8'd1, 8);
        check_eq("mid_cfg",  m_cfg, 64'h0);
        check_eq("mid_ar",   m_ar,  64'h2);
        check_eq("mid_lw",   m_lw,  64'h8);
        check_eq("mid_done", m_dn,  64'h10);

        // Reset during READ of group 1 (K4, four groups)
        set_default_pats();
        rst_pat[5] = 1'b1;
        run_job(5'b01000, 8'd4, 8);
        check_eq("rst_pre_gi", {56'd0, gi_v[5]}, 64'd1);
        check_eq("rst_re",     m_re, 64'h2C);
        check_eq("rst_rl",     m_rl, 64'h2C);
        check_eq("rst_lw",     m_lw, 64'h10);
        check_eq("rst_busy",   m_bz, 64'h3E);
        check_eq("rst_gi6",    {56'd0, gi_v[6]}, 64'd0);
        check_eq("rst_done",   m_dn, 64'h0);

        // A fresh job after the reset runs in full
        set_default_pats();
        run_job(5'b00001, 8'd1, 8);
        check_eq("post_ar",   m_ar, 64'h2);
        check_eq("post_re",   m_re, 64'h4);
        check_eq("post_lw",   m_lw, 64'h8);
        check_eq("post_done", m_dn, 64'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
